// File: rtl/params_pkg.sv
// Shared core parameters and the multiply-pipe stage record.
// The hazard unit and writeback index the multiply stages through MUL_STAGES.
package params_pkg;
  localparam int REGISTER_WIDTH = 5;
  localparam int MUL_STAGES     = 5;
  localparam int MUL_DATA_WIDTH = 32;

  // d0/d1/d2 change meaning per stage: operands, partial products, cross sum, result.
  typedef struct packed {
    logic                      valid;
    logic [REGISTER_WIDTH-1:0] wr_reg;
    logic [MUL_DATA_WIDTH-1:0] d0;
    logic [MUL_DATA_WIDTH-1:0] d1;
    logic [MUL_DATA_WIDTH-1:0] d2;
  } mul_stage_t;
endpackage

// File: rtl/mul_stage_reg.sv
// One multiply-pipe stage register: hold, advance, flush and async clear.
// Payload only loads with a valid entry so bubbles leave data untouched.
module mul_stage_reg
  import params_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       flush,
  input  mul_stage_t d,
  output mul_stage_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (flush) begin
      q.valid <= 1'b0;
    end else if (advance) begin
      if (d.valid) q <= d;
      else         q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mul_ex_pipeline.sv
// Fixed 5-stage integer multiply pipe (E1..E5) feeding writeback from E5.
// The whole pipe stalls while E5 holds a result that writeback has not granted.
module mul_ex_pipeline #(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
  parameter int NUM_STAGES     = 5
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     issue_valid_i,
  input  logic                                     bubble_i,
  input  logic                                     flush_i,
  input  logic [DATA_WIDTH-1:0]                    src_a_i,
  input  logic [DATA_WIDTH-1:0]                    src_b_i,
  input  logic [REGISTER_WIDTH-1:0]                wr_reg_i,
  input  logic                                     wb_ready_i,
  output logic [NUM_STAGES-1:0]                    stage_valid_o,
  output logic [NUM_STAGES-1:0][REGISTER_WIDTH-1:0] stage_wr_reg_o,
  output logic                                     wb_valid_o,
  output logic [REGISTER_WIDTH-1:0]                wb_reg_o,
  output logic [DATA_WIDTH-1:0]                    wb_data_o,
  output logic                                     ex_allowed_wb_o,
  output logic                                     busy_o
);
  import params_pkg::*;

  localparam int H = DATA_WIDTH / 2;

  if (NUM_STAGES != MUL_STAGES || DATA_WIDTH != MUL_DATA_WIDTH ||
      REGISTER_WIDTH != params_pkg::REGISTER_WIDTH) begin : g_bad_cfg
    $error("mul_ex_pipeline: unsupported NUM_STAGES/DATA_WIDTH/REGISTER_WIDTH");
  end

  function automatic logic [DATA_WIDTH-1:0] lo_half(input logic [DATA_WIDTH-1:0] x);
    return {{(DATA_WIDTH-H){1'b0}}, x[H-1:0]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] hi_half(input logic [DATA_WIDTH-1:0] x);
    return {{H{1'b0}}, x[DATA_WIDTH-1:H]};
  endfunction

  mul_stage_t stage_d [NUM_STAGES];
  mul_stage_t stage_q [NUM_STAGES];
  logic       advance;

  assign advance         = !stage_q[NUM_STAGES-1].valid || wb_ready_i;
  assign ex_allowed_wb_o = advance;

  // aH*bH only affects bits >= DATA_WIDTH, so three partial products suffice.
  always_comb begin
    stage_d[0]        = '0;
    stage_d[0].valid  = issue_valid_i && !bubble_i;
    stage_d[0].wr_reg = wr_reg_i;
    stage_d[0].d0     = src_a_i;
    stage_d[0].d1     = src_b_i;

    stage_d[1]    = stage_q[0];
    stage_d[1].d0 = lo_half(stage_q[0].d0) * lo_half(stage_q[0].d1);
    stage_d[1].d1 = hi_half(stage_q[0].d0) * lo_half(stage_q[0].d1);
    stage_d[1].d2 = lo_half(stage_q[0].d0) * hi_half(stage_q[0].d1);

    stage_d[2]    = stage_q[1];
    stage_d[2].d1 = stage_q[1].d1 + stage_q[1].d2;
    stage_d[2].d2 = '0;

    stage_d[3]    = stage_q[2];
    stage_d[3].d0 = stage_q[2].d0 + (stage_q[2].d1 << H);
    stage_d[3].d1 = '0;

    stage_d[4] = stage_q[3];
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    mul_stage_reg u_reg (
      .clk     (clk_i),
      .rst     (rst_i),
      .advance (advance),
      .flush   (flush_i),
      .d       (stage_d[k]),
      .q       (stage_q[k])
    );
  end

  always_comb begin
    stage_valid_o  = '0;
    stage_wr_reg_o = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      stage_valid_o[k]  = stage_q[k].valid;
      stage_wr_reg_o[k] = stage_q[k].wr_reg;
    end
  end

  assign wb_valid_o = stage_q[NUM_STAGES-1].valid;
  assign wb_reg_o   = stage_q[NUM_STAGES-1].wr_reg;
  assign wb_data_o  = stage_q[NUM_STAGES-1].d0;
  assign busy_o     = |stage_valid_o;

endmodule

// File: tb/tb_mul_ex_pipeline.sv
// Directed bench for mul_ex_pipeline with hand-computed expected values.
module tb_mul_ex_pipeline;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid, bubble, flush, wb_ready;
  logic [31:0]     src_a, src_b;
  logic [4:0]      wr_reg;
  logic [4:0]      stage_valid;
  logic [4:0][4:0] stage_wr_reg;
  logic            wb_valid;
  logic [4:0]      wb_reg;
  logic [31:0]     wb_data;
  logic            ex_allowed_wb;
  logic            busy;

  int total = 0;
  int bad   = 0;

  mul_ex_pipeline dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .issue_valid_i  (issue_valid),
    .bubble_i       (bubble),
    .flush_i        (flush),
    .src_a_i        (src_a),
    .src_b_i        (src_b),
    .wr_reg_i       (wr_reg),
    .wb_ready_i     (wb_ready),
    .stage_valid_o  (stage_valid),
    .stage_wr_reg_o (stage_wr_reg),
    .wb_valid_o     (wb_valid),
    .wb_reg_o       (wb_reg),
    .wb_data_o      (wb_data),
    .ex_allowed_wb_o(ex_allowed_wb),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic bb, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r);
    issue_valid = iv;
    bubble      = bb;
    src_a       = a;
    src_b       = b;
    wr_reg      = r;
  endtask

  logic [31:0] t2_a [5] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000, 32'd3, 32'd12345};
  logic [31:0] t2_b [5] = '{32'hFFFF_FFFF, 32'd2, 32'h0001_0000, 32'hFFFF_FFFF, 32'd6789};
  logic [31:0] t2_r [5] = '{32'd1, 32'd0, 32'd0, 32'hFFFF_FFFD, 32'd83810205};

  initial begin
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    #3;
    chk("rst_valid", stage_valid, 5'b0);
    chk("rst_wrreg", stage_wr_reg, 25'b0);
    chk("rst_wbv", wb_valid, 1'b0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_wbreg", wb_reg, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_allowed", ex_allowed_wb, 1'b1);
    #20 rst = 1'b0;

    // 1: single issue walks E1..E5
    drive(1'b1, 1'b0, 32'd7, 32'd6, 5'd5);
    for (int k = 0; k < 5; k++) begin
      tick();
      drive(1'b0, 1'b0, '0, '0, '0);
      chk("t1_walk", stage_valid, 5'b1 << k);
      chk("t1_wbv", wb_valid, k == 4);
    end
    chk("t1_data", wb_data, 32'd42);
    chk("t1_reg", wb_reg, 5'd5);
    tick();
    chk("t1_idle", busy, 1'b0);

    // 2: back-to-back, wrap-around products
    for (int i = 0; i < 9; i++) begin
      if (i < 5) drive(1'b1, 1'b0, t2_a[i], t2_b[i], 5'(i + 1));
      else       drive(1'b0, 1'b0, '0, '0, '0);
      tick();
      if (i == 4) chk("t2_full", stage_valid, 5'b11111);
      if (i >= 4) begin
        chk("t2_wbv", wb_valid, 1'b1);
        chk("t2_data", wb_data, t2_r[i-4]);
        chk("t2_reg", wb_reg, 5'(i - 3));
      end
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("t2_drained", busy, 1'b0);

    // 3: writeback backpressure
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'(i + 2), 32'd10, 5'(i + 10));
      tick();
    end
    wb_ready = 1'b0;
    drive(1'b1, 1'b0, 32'd99, 32'd99, 5'd31);
    #1;
    chk("t3_allowed", ex_allowed_wb, 1'b0);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("t3_frz_valid", stage_valid, 5'b11111);
      chk("t3_frz_wrreg", stage_wr_reg, {5'd10, 5'd11, 5'd12, 5'd13, 5'd14});
      chk("t3_frz_data", wb_data, 32'd20);
      chk("t3_frz_reg", wb_reg, 5'd10);
    end
    wb_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("t3_wbv", wb_valid, 1'b1);
      chk("t3_data", wb_data, 32'(10 * (i + 2)));
      chk("t3_reg", wb_reg, 5'(i + 10));
    end
    tick();
    chk("t3_nostall_issue", busy, 1'b0);

    // 4: bubbles do not load E1
    drive(1'b1, 1'b1, 32'd5, 32'd5, 5'd7);
    for (int s = 0; s < 2; s++) begin
      tick();
      chk("t4_bub_valid", stage_valid[0], 1'b0);
      chk("t4_bub_hold", stage_wr_reg[0], 5'd14);
    end
    drive(1'b1, 1'b0, 32'd11, 32'd3, 5'd8);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0);
    chk("t4_e1_valid", stage_valid, 5'b00001);
    chk("t4_e1_reg", stage_wr_reg[0], 5'd8);
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk("t4_wbv", wb_valid, j == 4);
    end
    chk("t4_data", wb_data, 32'd33);
    chk("t4_reg", wb_reg, 5'd8);
    tick();

    // 5: flush while E5 hands off
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'(i + 1), 32'd100, 5'(i + 20));
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("t5_pre_valid", stage_valid, 5'b11110);
    flush = 1'b1;
    #1;
    chk("t5_wbv", wb_valid, 1'b1);
    chk("t5_data", wb_data, 32'd100);
    chk("t5_reg", wb_reg, 5'd20);
    chk("t5_allowed", ex_allowed_wb, 1'b1);
    tick();
    flush = 1'b0;
    chk("t5_valid", stage_valid, 5'b0);
    chk("t5_busy", busy, 1'b0);
    tick();
    chk("t5_stays_empty", busy, 1'b0);

    // 6: async reset mid-flight, with E5 stalled
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'(i + 3), 32'd7, 5'(i + 1));
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    chk("t6_pre_valid", stage_valid, 5'b00111);
    #3 rst = 1'b1;
    #1;
    chk("t6_valid", stage_valid, 5'b0);
    chk("t6_wrreg", stage_wr_reg, 25'b0);
    chk("t6_wbv", wb_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_allowed", ex_allowed_wb, 1'b1);
    #3 rst = 1'b0;
    wb_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      tick();
      chk("t6_no_wb", wb_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_ex_pipeline.md
Name: mul_ex_pipeline

Overview:
Fixed-latency 5-stage integer multiply execution pipeline (E1..E5) that sits between decode and writeback, alongside the single-cycle ALU.
- Accepts one multiply per cycle from decode.
- Carries destination register and valid bits down the pipe; delivers the result to writeback from E5.
- Exports per-stage valid/destination state and the writeback-permission signal that the hazard unit consumes for RAW detection and EX stall generation.

Parameters:
DATA_WIDTH, 32, operand and result width
REGISTER_WIDTH, params_pkg::REGISTER_WIDTH, architectural register index width
NUM_STAGES, 5, pipeline depth; fixed at 5, elaboration-time assertion if changed

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
issue_valid_i  input  1  decode presents a multiply this cycle
bubble_i  input  1  insert bubble into E1 instead of the issue (driven by hazard unit ex_bubble)
flush_i  input  1  kill all in-flight multiplies
src_a_i  input  DATA_WIDTH  operand A
src_b_i  input  DATA_WIDTH  operand B
wr_reg_i  input  REGISTER_WIDTH  destination register
wb_ready_i  input  1  writeback port grants E5 this cycle
stage_valid_o  output  NUM_STAGES  valid bit of E1..E5 (bit 0 = E1)
stage_wr_reg_o  output  NUM_STAGES x REGISTER_WIDTH  destination of E1..E5
wb_valid_o  output  1  E5 holds a finished result
wb_reg_o  output  REGISTER_WIDTH  E5 destination
wb_data_o  output  DATA_WIDTH  E5 result
ex_allowed_wb_o  output  1  pipe may advance this cycle
busy_o  output  1  any stage valid

Behaviour:
Reset and basic timing:
- Clock clk_i. rst_i is asynchronous and active-high.
- On reset: all stage valid bits 0, destination registers 0, data registers 0.
- Consequently every output is 0 at reset, except ex_allowed_wb_o = 1.
- Latency: an issue accepted at edge N is in E1 after N. It reaches E5 (wb_valid_o = 1) after edge N+4 when no stalls occur.

Advance rule:
- advance = !wb_valid_o || wb_ready_i.
- ex_allowed_wb_o = advance, combinational.

When advance = 1, on each edge:
- E(k+1) <= E(k) for k = 1..4. This copies valid, wr_reg and partial data.
- E1.valid <= issue_valid_i && !bubble_i.
- E1.wr_reg and operands are captured only when that valid is 1. Otherwise they hold their old value (no toggling on bubbles).
- E5 is consumed when wb_ready_i = 1. It is replaced by E4 in the same edge.

When advance = 0:
- All stages hold.
- issue_valid_i is ignored and not accepted. Upstream must keep it asserted; the hazard unit stalls decode in this case.

Flush:
- flush_i = 1 clears all valid bits on the next edge.
- Flush has priority over advance and issue.
- A result present in E5 with wb_ready_i = 1 in the flush cycle is still written back (handshake completes); everything else is dropped.

Arithmetic:
- wb_data_o = (src_a * src_b) mod 2^DATA_WIDTH. This is identical for signed and unsigned operands.
- Internal split:
  - E1 registers the operands.
  - E2 forms the three half-width partial products (aL·bL, aH·bL, aL·bH).
  - E3 sums the cross terms.
  - E4 shifts them and adds to aL·bL.
  - E5 holds the final result.
- Each stage's data moves only under the same advance/valid rule as its valid bit.

Destination register:
- wr_reg = 0 is carried normally.
- The pipeline does not suppress it; writeback discards x0 writes.

Outputs:
- wb_valid_o = stage_valid_o[4]; wb_reg_o and wb_data_o come from E5.
- busy_o = OR of all stage valid bits.
- All stage outputs are direct register outputs, with no combinational path from inputs.

Simultaneous events:
- Issue together with E5 write under wb_ready_i = 1: both happen on the same edge. Throughput is 1/cycle.
- wb_ready_i asserted while wb_valid_o = 0: no effect.

Reset mid-operation:
- Asynchronous clear of all valid bits. In-flight results are lost, with no writeback.

Decomposition:
- params_pkg receives a mul_stage_t struct (valid, wr_reg, partial data fields) and a localparam MUL_STAGES = 5.
- Hazard unit and writeback import MUL_STAGES for stage indexing.
- One natural sub-module: mul_stage_reg. It is a single stage register with hold/advance/flush/async-reset. It is instantiated 5 times with per-stage combinational data logic between instances in the top.

Test Plan:
1. Single issue: a=7, b=6, wr_reg=5, wb_ready_i=1 constantly. Required response:
   - stage_valid_o walks 00001→10000 over 5 cycles.
   - wb_valid_o=1 with wb_data_o=42, wb_reg_o=5 exactly 4 cycles after E1.
2. Back-to-back issue of 5 ops with no stall: (0xFFFFFFFF×0xFFFFFFFF→1), (0x80000000×2→0), (0x10000×0x10000→0), (3×−1→0xFFFFFFFD), (12345×6789→83810205). Required response:
   - 5 consecutive wb_valid_o cycles, in order, with the correct values.
3. Writeback backpressure: fill the pipe, then hold wb_ready_i=0 for 3 cycles. Required response:
   - ex_allowed_wb_o=0 and all stage contents frozen.
   - issue_valid_i during the stall is not accepted.
   - On release, results drain in order with none lost or duplicated.
4. Bubble: issue_valid_i=1 with bubble_i=1 for 2 cycles, then bubble_i=0. Required response:
   - E1 valid pattern 0,0,1; the first result appears only from the third issue.
5. Flush with E5 handshaking: pipe holds 4 ops, wb_ready_i=1, flush_i=1 for one cycle. Required response:
   - E5 result written back that cycle.
   - Next cycle stage_valid_o=0 and busy_o=0.
6. Async reset mid-flight: assert rst_i between clock edges with 3 ops in flight. Required response:
   - All outputs zero immediately (ex_allowed_wb_o=1) without waiting for a clock edge.
   - No wb_valid_o after release.
